alu_issue_ctrl: RTL and testbench

Sequencing stage directly upstream of the combinational ALU. It accepts one operation request (A, B, OP) over a valid/ready handshake and drives the ALU operand and opcode ports, holding them stable for a configurable settle window. It then captures the ALU result Z and overflow OV into registers and presents them downstream over a second valid/ready handshake. This turns the combinational ALU into a registered, flow-controlled unit for the datapath.

---
 rtl/alu_issue_ctrl.sv | 131 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Registered, flow-controlled issue stage in front of a combinational ALU.
// Optional sticky overflow flag: define ALU_ISSUE_OV_STICKY_EN.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// EXEC  | operands held on the ALU, settle counter running
// DONE  | captured result offered downstream, out_valid high
module alu_issue_ctrl #(
    parameter int nIO    = 8,
    parameter int SETTLE = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [nIO-1:0] in_a_i,
    input  logic [nIO-1:0] in_b_i,
    input  logic [2:0]     in_op_i,
    output logic [nIO-1:0] alu_a_o,
    output logic [nIO-1:0] alu_b_o,
    output logic [2:0]     alu_op_o,
    input  logic [nIO-1:0] alu_z_i,
    input  logic           alu_ov_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [nIO-1:0] out_z_o,
    output logic           out_ov_o,
    output logic [2:0]     out_op_o,
    output logic           busy_o,
    output logic           ov_sticky_o,
    input  logic           ov_clear_i
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t         state_q, state_d;
    logic [3:0]     cnt_q;
    logic [nIO-1:0] a_q, b_q, z_q;
    logic [2:0]     op_q, oop_q;
    logic           ov_q;
    logic           accept, capture;

    assign accept  = (state_q == IDLE) && in_valid_i;
    assign capture = (state_q == EXEC) && (cnt_q == 4'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid_i) state_d = EXEC;
            EXEC:    if (cnt_q == 4'd0) state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == IDLE);
        out_valid_o = (state_q == DONE);
        busy_o      = (state_q != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= 3'd0;
            z_q   <= '0;
            ov_q  <= 1'b0;
            oop_q <= 3'd0;
        end else begin
            if (accept) begin
                a_q   <= in_a_i;
                b_q   <= in_b_i;
                op_q  <= in_op_i;
                cnt_q <= SETTLE_M1;
            end else if ((state_q == EXEC) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            // Result registers only move on capture so they stay valid through backpressure.
            if (capture) begin
                z_q   <= alu_z_i;
                ov_q  <= alu_ov_i;
                oop_q <= op_q;
            end
        end
    end

    assign alu_a_o  = a_q;
    assign alu_b_o  = b_q;
    assign alu_op_o = op_q;
    assign out_z_o  = z_q;
    assign out_ov_o = ov_q;
    assign out_op_o = oop_q;

`ifdef ALU_ISSUE_OV_STICKY_EN
    logic sticky_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sticky_q <= 1'b0;
        end else if (capture && alu_ov_i) begin
            sticky_q <= 1'b1;
        end else if (ov_clear_i) begin
            sticky_q <= 1'b0;
        end
    end

    assign ov_sticky_o = sticky_q;
`else
    logic unused_ov_clear;

    assign unused_ov_clear = ov_clear_i;
    assign ov_sticky_o     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: one instance with SETTLE=1 and one with SETTLE=4,
// each driving an adder stub; expectations come from integer arithmetic.
module tb_alu_issue_ctrl;

`ifdef ALU_ISSUE_OV_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit sticky_m = 1'b0;

    // SETTLE=1 instance
    logic       in_valid1, in_ready1, out_valid1, out_ready1, out_ov1, busy1, sticky1, ov_clear1, ov1;
    logic [7:0] in_a1, in_b1, alu_a1, alu_b1, z1, out_z1;
    logic [2:0] in_op1, alu_op1, out_op1;

    // SETTLE=4 instance
    logic       in_valid4, in_ready4, out_valid4, out_ready4, out_ov4, busy4, sticky4, ov_clear4, ov4;
    logic [7:0] in_a4, in_b4, alu_a4, alu_b4, z4, out_z4, mask4, sum4;
    logic [2:0] in_op4, alu_op4, out_op4;

    assign z1   = alu_a1 + alu_b1;
    assign ov1  = (alu_a1[7] == alu_b1[7]) && (z1[7] != alu_a1[7]);
    assign sum4 = alu_a4 + alu_b4;
    assign z4   = sum4 ^ mask4;
    assign ov4  = (alu_a4[7] == alu_b4[7]) && (sum4[7] != alu_a4[7]);

    alu_issue_ctrl #(.nIO(8), .SETTLE(1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .in_a_i(in_a1), .in_b_i(in_b1), .in_op_i(in_op1),
        .alu_a_o(alu_a1), .alu_b_o(alu_b1), .alu_op_o(alu_op1),
        .alu_z_i(z1), .alu_ov_i(ov1),
        .out_valid_o(out_valid1), .out_ready_i(out_ready1),
        .out_z_o(out_z1), .out_ov_o(out_ov1), .out_op_o(out_op1),
        .busy_o(busy1), .ov_sticky_o(sticky1), .ov_clear_i(ov_clear1)
    );

    alu_issue_ctrl #(.nIO(8), .SETTLE(4)) dut4 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid4), .in_ready_o(in_ready4),
        .in_a_i(in_a4), .in_b_i(in_b4), .in_op_i(in_op4),
        .alu_a_o(alu_a4), .alu_b_o(alu_b4), .alu_op_o(alu_op4),
        .alu_z_i(z4), .alu_ov_i(ov4),
        .out_valid_o(out_valid4), .out_ready_i(out_ready4),
        .out_z_o(out_z4), .out_ov_o(out_ov4), .out_op_o(out_op4),
        .busy_o(busy4), .ov_sticky_o(sticky4), .ov_clear_i(ov_clear4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_sticky();
        return STICKY_ON ? sticky_m : 1'b0;
    endfunction

    // One full transaction on the SETTLE=1 instance. hold = cycles of
    // out_ready=0 after out_valid rises; clr = ov_clear on the capture edge.
    task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input int hold, input bit clr);
        int          s, n;
        logic [31:0] sv;
        logic [7:0]  ez;
        logic        eov;
        s   = int'($signed(a)) + int'($signed(b));
        sv  = s;
        ez  = sv[7:0];
        eov = (s > 127) || (s < -128);

        chk("in_ready_idle", in_ready1, 1);
        in_valid1 = 1'b1; in_a1 = a; in_b1 = b; in_op1 = op;
        out_ready1 = (hold == 0);
        tick();
        in_valid1 = 1'b0; in_a1 = 8'($urandom); in_b1 = 8'($urandom); in_op1 = 3'($urandom);
        ov_clear1 = clr;
        chk("alu_a_latched", alu_a1, a);
        chk("alu_b_latched", alu_b1, b);
        chk("alu_op_latched", alu_op1, op);
        chk("busy_exec", busy1, 1);
        chk("in_ready_exec", in_ready1, 0);
        n = 0;
        while (!out_valid1 && n < 20) begin
            tick();
            n++;
            ov_clear1 = 1'b0;
        end
        if (eov) sticky_m = 1'b1;
        else if (clr) sticky_m = 1'b0;
        chk("latency", n, 1);
        chk("out_z", out_z1, ez);
        chk("out_ov", out_ov1, eov);
        chk("out_op", out_op1, op);
        chk("sticky", sticky1, exp_sticky());
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                in_valid1 = 1'b1; in_a1 = ~a;
            end
            tick();
            in_valid1 = 1'b0;
            chk("bp_valid", out_valid1, 1);
            chk("bp_z", out_z1, ez);
            chk("bp_op", out_op1, op);
            chk("bp_in_ready", in_ready1, 0);
            chk("bp_alu_a", alu_a1, a);
        end
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        chk("done_valid_low", out_valid1, 0);
        chk("done_idle", in_ready1, 1);
        chk("done_busy", busy1, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid1 = 0; in_a1 = 0; in_b1 = 0; in_op1 = 0; out_ready1 = 0; ov_clear1 = 0;
        in_valid4 = 0; in_a4 = 0; in_b4 = 0; in_op4 = 0; out_ready4 = 0; ov_clear4 = 0;
        mask4 = 8'h00;
        tick();
        chk("rst_in_ready", in_ready1, 1);
        chk("rst_out_valid", out_valid1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_out_z", out_z1, 0);
        chk("rst_alu_a", alu_a1, 0);
        chk("rst_alu_b", alu_b1, 0);
        chk("rst_alu_op", alu_op1, 0);
        chk("rst_out_ov", out_ov1, 0);
        chk("rst_out_op", out_op1, 0);
        chk("rst_sticky", sticky1, 0);
        chk("rst_in_ready4", in_ready4, 1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_a1 = 8'($urandom);
            tick();
            chk("idle_hold_ready", in_ready1, 1);
            chk("idle_hold_valid", out_valid1, 0);
            chk("idle_hold_alu_a", alu_a1, 0);
            chk("idle_hold_busy", busy1, 0);
        end

        run1(8'd100, 8'd27, 3'b000, 0, 1'b0);
        run1(8'd100, 8'd28, 3'b000, 0, 1'b0);
        run1(8'd1, 8'd1, 3'b000, 0, 1'b0);
        ov_clear1 = 1'b1;
        tick();
        ov_clear1 = 1'b0;
        sticky_m = 1'b0;
        chk("sticky_cleared", sticky1, exp_sticky());
        run1(8'd100, 8'd28, 3'b000, 0, 1'b1);
        run1(8'd5, 8'd6, 3'b101, 5, 1'b0);

        for (int k = 0; k < 24; k++) begin
            run1(8'($urandom), 8'($urandom), 3'($urandom), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) begin
                if (($urandom_range(0, 1) == 0)) begin
                    ov_clear1 = 1'b1;
                    sticky_m = 1'b0;
                end
                tick();
                ov_clear1 = 1'b0;
                chk("rand_gap_sticky", sticky1, exp_sticky());
            end
        end

        // SETTLE=4: operands held for edges 1..3, a corrupted Z before edge 4 is ignored
        in_valid4 = 1'b1; in_a4 = 8'd10; in_b4 = 8'd20; in_op4 = 3'd2;
        tick();
        in_valid4 = 1'b0; in_a4 = 8'hAA; in_b4 = 8'h55; in_op4 = 3'd7;
        mask4 = 8'hFF;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("s4_valid_low", out_valid4, 0);
            chk("s4_alu_a", alu_a4, 10);
            chk("s4_alu_b", alu_b4, 20);
            chk("s4_alu_op", alu_op4, 2);
        end
        mask4 = 8'h00;
        tick();
        chk("s4_valid", out_valid4, 1);
        chk("s4_out_z", out_z4, 30);
        chk("s4_out_op", out_op4, 2);
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        chk("s4_done", out_valid4, 0);

        // reset in the middle of EXEC
        in_valid4 = 1'b1; in_a4 = 8'd3; in_b4 = 8'd4; in_op4 = 3'd1;
        tick();
        in_valid4 = 1'b0;
        tick();
        tick();
        chk("mid_busy", busy4, 1);
        rst = 1'b1;
        sticky_m = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid4, 0);
        chk("mid_rst_busy", busy4, 0);
        chk("mid_rst_ready", in_ready4, 1);
        chk("mid_rst_alu_a", alu_a4, 0);
        chk("mid_rst_out_z", out_z4, 0);
        chk("mid_rst_out_op", out_op4, 0);
        chk("mid_rst_sticky1", sticky1, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_valid", out_valid4, 0);
        end
        in_valid4 = 1'b1; in_a4 = 8'd7; in_b4 = 8'd9; in_op4 = 3'd4;
        tick();
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 20) begin
            tick();
            n++;
        end
        chk("post_rst_latency", n, 4);
        chk("post_rst_z", out_z4, 16);
        chk("post_rst_op", out_op4, 4);
        chk("post_rst_ov", out_ov4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
